// File: rtl/enc_dec_pkg.sv
// -----------------------------------------------------------------------------
// enc_dec_pkg
// Shared definitions for the stream encoder and its future decoder:
//   - codeword mode encodings (small / medium / large / reserved)
//   - per-mode data and parity field widths
//   - per-mode parity masks: parity bit k is the XOR of the data bits whose
//     positions are set in mask k.
// Medium and large masks follow an extended-Hamming layout: data bits fill
// the non-power-of-two positions 3,5,6,7,9,... in order, parity bit k
// covers the positions with address bit k set, and the top parity bit
// covers every data bit.
// -----------------------------------------------------------------------------
package enc_dec_pkg;

  typedef enum logic [1:0] {
    MODE_SMALL  = 2'b00,
    MODE_MEDIUM = 2'b01,
    MODE_LARGE  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam int SMALL_DATA_W  = 4;
  localparam int SMALL_PAR_W   = 4;
  localparam int MEDIUM_DATA_W = 11;
  localparam int MEDIUM_PAR_W  = 5;
  localparam int LARGE_DATA_W  = 26;
  localparam int LARGE_PAR_W   = 6;

  localparam int MAX_DATA_W = 26;
  localparam int MAX_PAR_W  = 6;
  localparam int CW_W       = 32;

  // Index k of each array is the mask for parity bit k.
  localparam logic [SMALL_PAR_W-1:0][SMALL_DATA_W-1:0] SMALL_MASK = {
    4'h7, 4'hE, 4'hD, 4'hB
  };

  localparam logic [MEDIUM_PAR_W-1:0][MEDIUM_DATA_W-1:0] MEDIUM_MASK = {
    11'h7FF, 11'h7F0, 11'h78E, 11'h66D, 11'h55B
  };

  localparam logic [LARGE_PAR_W-1:0][LARGE_DATA_W-1:0] LARGE_MASK = {
    26'h3FF_FFFF, 26'h3FF_F800, 26'h3FC_07F0,
    26'h3C3_C78E, 26'h333_366D, 26'h2AA_AD5B
  };

  // Selects the data field that belongs to a mode; bits above it are ignored.
  function automatic logic [MAX_DATA_W-1:0] data_field_mask(input mode_e mode);
    logic [MAX_DATA_W-1:0] m;
    case (mode)
      MODE_SMALL:  m = 26'h000_000F;
      MODE_MEDIUM: m = 26'h000_07FF;
      MODE_LARGE:  m = 26'h3FF_FFFF;
      default:     m = 26'h000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/enc_parity_gen.sv
// -----------------------------------------------------------------------------
// enc_parity_gen
// Purely combinational parity generator. Each parity bit is the XOR of the
// data bits selected by its mode's mask from enc_dec_pkg.
// Ports:
//   data_i   [25:0] LSB-aligned data field
//   mode_i          codeword mode (reserved mode yields zero parity)
//   parity_o [5:0]  parity word, LSB-aligned; unused upper bits are zero
// -----------------------------------------------------------------------------
module enc_parity_gen
  import enc_dec_pkg::*;
(
  input  logic [MAX_DATA_W-1:0] data_i,
  input  mode_e                 mode_i,
  output logic [MAX_PAR_W-1:0]  parity_o
);

  // Mask-and-reduce per parity bit for the selected mode.
  always_comb begin
    parity_o = '0;
    case (mode_i)
      MODE_SMALL: begin
        for (int k = 0; k < SMALL_PAR_W; k++) begin
          parity_o[k] = ^(data_i[SMALL_DATA_W-1:0] & SMALL_MASK[k]);
        end
      end
      MODE_MEDIUM: begin
        for (int k = 0; k < MEDIUM_PAR_W; k++) begin
          parity_o[k] = ^(data_i[MEDIUM_DATA_W-1:0] & MEDIUM_MASK[k]);
        end
      end
      MODE_LARGE: begin
        for (int k = 0; k < LARGE_PAR_W; k++) begin
          parity_o[k] = ^(data_i[LARGE_DATA_W-1:0] & LARGE_MASK[k]);
        end
      end
      default: parity_o = '0;
    endcase
  end

endmodule

// File: rtl/stream_encoder.sv
// -----------------------------------------------------------------------------
// stream_encoder
// Two-stage valid/ready pipeline that turns LSB-aligned payload beats into
// {data, parity} codewords (8, 16 or 32 bits depending on in_mode).
// Stage 1 registers masked data, mode and parity; stage 2 is the output
// register. Reserved-mode beats are accepted, dropped, and flagged on
// mode_err one cycle after acceptance.
// Parameters: AMBA_WORD (bus width, multiple of 32), CNT_WIDTH (counter width)
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input handshake
//   in_mode[1:0], data_in    beat mode and payload
//   out_valid/out_ready      output handshake
//   enc_out, out_mode        codeword (upper bits zero) and its mode
//   mode_err                 one-cycle pulse per dropped reserved beat
//   enc_count                output-transfer counter, saturating
//                            (only when STREAM_ENCODER_STATS_EN is defined)
// Build option: define STREAM_ENCODER_STATS_EN to add enc_count.
// -----------------------------------------------------------------------------
module stream_encoder
  import enc_dec_pkg::*;
#(
  parameter int AMBA_WORD = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [AMBA_WORD-1:0] data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AMBA_WORD-1:0] enc_out,
  output logic [1:0]           out_mode,
  output logic                 mode_err
`ifdef STREAM_ENCODER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] enc_count
`endif
);

  mode_e                 mode_s;
  logic [MAX_DATA_W-1:0] data_fld_s;
  logic [MAX_PAR_W-1:0]  parity_s;
  logic                  in_fire_s;
  logic                  out_fire_s;
  logic                  s1_advance_s;
  logic [CW_W-1:0]       cw_s;
  logic                  unused_s;

  logic                  s1_valid_q, s1_valid_d;
  mode_e                 s1_mode_q, s1_mode_d;
  logic [MAX_DATA_W-1:0] s1_data_q, s1_data_d;
  logic [MAX_PAR_W-1:0]  s1_par_q, s1_par_d;
  logic                  mode_err_q, mode_err_d;

  logic                  out_valid_q, out_valid_d;
  logic [AMBA_WORD-1:0]  enc_out_q, enc_out_d;
  mode_e                 out_mode_q, out_mode_d;

  assign mode_s     = mode_e'(in_mode);
  assign data_fld_s = data_in[MAX_DATA_W-1:0] & data_field_mask(mode_s);
  assign unused_s   = ^data_in[AMBA_WORD-1:MAX_DATA_W];

  enc_parity_gen u_parity (
    .data_i   (data_fld_s),
    .mode_i   (mode_s),
    .parity_o (parity_s)
  );

  // Stage 1 drains into stage 2 whenever stage 2 is empty or being consumed.
  assign s1_advance_s = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready     = !rst && (!s1_valid_q || s1_advance_s);
  assign in_fire_s    = in_valid && in_ready;
  assign out_fire_s   = out_valid_q && out_ready;

  // Stage 1 next state: load non-reserved beats, empty on advance, else hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_data_d  = s1_data_q;
    s1_par_d   = s1_par_q;
    mode_err_d = in_fire_s && (mode_s == MODE_RSVD);
    if (in_fire_s && (mode_s != MODE_RSVD)) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = mode_s;
      s1_data_d  = data_fld_s;
      s1_par_d   = parity_s;
    end else if (s1_advance_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Codeword assembly from stage 1: {data field, parity field}, LSB-aligned.
  always_comb begin
    cw_s = '0;
    case (s1_mode_q)
      MODE_SMALL:  cw_s = {24'h00_0000, s1_data_q[SMALL_DATA_W-1:0],
                           s1_par_q[SMALL_PAR_W-1:0]};
      MODE_MEDIUM: cw_s = {16'h0000, s1_data_q[MEDIUM_DATA_W-1:0],
                           s1_par_q[MEDIUM_PAR_W-1:0]};
      MODE_LARGE:  cw_s = {s1_data_q[LARGE_DATA_W-1:0],
                           s1_par_q[LARGE_PAR_W-1:0]};
      default:     cw_s = '0;
    endcase
  end

  // Stage 2 next state: refill on advance, empty on consumption, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    enc_out_d   = enc_out_q;
    out_mode_d  = out_mode_q;
    if (s1_advance_s) begin
      out_valid_d           = 1'b1;
      enc_out_d             = '0;
      enc_out_d[CW_W-1:0]   = cw_s;
      out_mode_d            = s1_mode_q;
    end else if (out_fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_SMALL;
      s1_data_q   <= '0;
      s1_par_q    <= '0;
      mode_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      enc_out_q   <= '0;
      out_mode_q  <= MODE_SMALL;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_data_q   <= s1_data_d;
      s1_par_q    <= s1_par_d;
      mode_err_q  <= mode_err_d;
      out_valid_q <= out_valid_d;
      enc_out_q   <= enc_out_d;
      out_mode_q  <= out_mode_d;
    end
  end

  assign out_valid = out_valid_q;
  assign enc_out   = enc_out_q;
  assign out_mode  = out_mode_q;
  assign mode_err  = mode_err_q;

`ifdef STREAM_ENCODER_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Count output transfers, sticking at all-ones.
  always_comb begin
    if (out_fire_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign enc_count = cnt_q;
`endif

endmodule

// File: tb/tb_stream_encoder.sv
// -----------------------------------------------------------------------------
// tb_stream_encoder
// Self-checking bench for stream_encoder (default 32-bit bus). A reference
// model computes codewords from the encoding rules (explicit small-mode
// equations, extended-Hamming positions for medium/large) and a scoreboard
// queue tracks accepted beats. Set STREAM_ENCODER_STATS_EN to also check
// enc_count.
// -----------------------------------------------------------------------------
module tb_stream_encoder;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode = 2'b00;
  logic [AW-1:0] data_in = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] enc_out;
  logic [1:0]    out_mode;
  logic          mode_err;
`ifdef STREAM_ENCODER_STATS_EN
  logic [15:0]   enc_count;
`endif

  stream_encoder #(.AMBA_WORD(AW), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enc_out   (enc_out),
    .out_mode  (out_mode),
    .mode_err  (mode_err)
`ifdef STREAM_ENCODER_STATS_EN
    ,
    .enc_count (enc_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder built from the encoding rules.
  function automatic logic [31:0] ref_encode(input logic [1:0] mode, input logic [31:0] data);
    logic [3:0]  d;
    logic [5:0]  h;
    logic [25:0] dv;
    logic        all;
    int          nd, np, di, pos;
    logic [31:0] cw;
    cw = 32'h0;
    if (mode == 2'b00) begin
      d  = data[3:0];
      cw = {24'h0, d, d[2]^d[1]^d[0], d[3]^d[2]^d[1], d[3]^d[2]^d[0], d[3]^d[1]^d[0]};
    end else if (mode != 2'b11) begin
      nd  = (mode == 2'b01) ? 11 : 26;
      np  = (mode == 2'b01) ? 4 : 5;
      dv  = 26'h0;
      for (int i = 0; i < nd; i++) dv[i] = data[i];
      h   = 6'h0;
      all = 1'b0;
      di  = 0;
      pos = 1;
      while (di < nd) begin
        if ((pos & (pos - 1)) != 0) begin
          if (dv[di]) begin
            h   = h ^ pos[5:0];
            all = ~all;
          end
          di++;
        end
        pos++;
      end
      h[np] = all;
      if (mode == 2'b01) cw = {16'h0, dv[10:0], h[4:0]};
      else               cw = {dv, h};
    end
    return cw;
  endfunction

  typedef struct {
    logic [31:0] cw;
    logic [1:0]  mode;
  } exp_t;

  exp_t        exp_q[$];
  int          out_cnt = 0;
  int          err_cnt = 0;
  logic        err_exp = 1'b0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_enc = 32'h0;
  logic [1:0]  hold_mode = 2'b00;
  logic [15:0] exp_cnt = 16'h0;

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t it;
    if (rst) begin
      check_eq("rst_in_ready", in_ready, 1'b0);
      exp_q.delete();
      err_exp   = 1'b0;
      hold_pend = 1'b0;
      exp_cnt   = 16'h0;
    end else begin
      check_eq("mode_err", mode_err, err_exp);
      if (mode_err) err_cnt++;
      if (hold_pend) begin
        check_eq("hold_valid", out_valid, 1'b1);
        check_eq("hold_enc", enc_out, hold_enc);
        check_eq("hold_mode", out_mode, hold_mode);
      end
`ifdef STREAM_ENCODER_STATS_EN
      check_eq("enc_count", enc_count, exp_cnt);
`endif
      if (out_valid && out_ready) begin
        check_eq("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          it = exp_q.pop_front();
          check_eq("enc_out", enc_out, it.cw);
          check_eq("out_mode", out_mode, it.mode);
        end
        out_cnt++;
        if (exp_cnt != 16'hFFFF) exp_cnt++;
      end
      if (in_valid && in_ready && in_mode != 2'b11) begin
        it.cw   = ref_encode(in_mode, data_in);
        it.mode = in_mode;
        exp_q.push_back(it);
      end
      err_exp   = in_valid && in_ready && (in_mode == 2'b11);
      hold_pend = out_valid && !out_ready;
      hold_enc  = enc_out;
      hold_mode = out_mode;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [1:0] m, input logic [31:0] d);
    logic acc;
    int   waited;
    acc     = 1'b0;
    waited  = 0;
    in_valid = 1'b1;
    in_mode  = m;
    data_in  = d;
    while (!acc && waited <= 200) begin
      @(negedge clk);
      acc = in_ready;
      step();
      waited++;
    end
    if (!acc) check_eq("send_timeout", waited, 0);
    in_valid = 1'b0;
  endtask

  // Let the pipeline empty with the sink ready (bounded).
  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    step();
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  int   base_out, base_err;
  logic bp_run;

  initial begin
    // Reset state.
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_enc_out", enc_out, 32'h0);
    check_eq("rst_out_mode", out_mode, 2'b00);
    check_eq("rst_mode_err", mode_err, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", in_ready, 1'b1);
    step();

    // Small data 0x1: latency and value.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    data_in   = 32'h1;
    @(negedge clk);
    check_eq("lat_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_stage1", out_valid, 1'b0);
    @(negedge clk);
    check_eq("lat_valid", out_valid, 1'b1);
    check_eq("lat_enc", enc_out, 32'h0000_001B);
    check_eq("lat_mode", out_mode, 2'b00);
    drain();

    // Small with upper bits set.
    send(2'b00, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    check_eq("small_ff", enc_out, 32'h0000_00FF);
    drain();

    // Large then medium back-to-back, one beat per cycle.
    step();
    in_valid = 1'b1;
    in_mode  = 2'b10;
    data_in  = 32'h0;
    @(negedge clk);
    check_eq("b2b_acc0", in_ready, 1'b1);
    step();
    in_mode = 2'b01;
    @(negedge clk);
    check_eq("b2b_acc1", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_v0", out_valid, 1'b1);
    check_eq("b2b_m0", out_mode, 2'b10);
    check_eq("b2b_e0", enc_out, 32'h0);
    @(negedge clk);
    check_eq("b2b_v1", out_valid, 1'b1);
    check_eq("b2b_m1", out_mode, 2'b01);
    check_eq("b2b_e1", enc_out, 32'h0);
    drain();

    // Eight beats with a three-cycle sink stall.
    base_out = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 2)), $urandom());
      end
      begin
        repeat (4) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("stall_count", out_cnt - base_out, 8);

    // Reserved beat between two small beats.
    base_out = out_cnt;
    base_err = err_cnt;
    send(2'b00, 32'h5);
    send(2'b11, 32'h1234_5678);
    send(2'b00, 32'hA);
    drain();
    repeat (2) step();
    check_eq("rsvd_out_count", out_cnt - base_out, 2);
    check_eq("rsvd_err_count", err_cnt - base_err, 1);

    // Reset with two beats in flight.
    base_out  = out_cnt;
    out_ready = 1'b0;
    send(2'b01, $urandom());
    send(2'b10, $urandom());
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", out_valid, 1'b0);
    check_eq("midrst_ready_up", in_ready, 1'b1);
`ifdef STREAM_ENCODER_STATS_EN
    check_eq("midrst_count", enc_count, 16'h0);
`endif
    out_ready = 1'b1;
    repeat (6) step();
    check_eq("midrst_no_out", out_cnt - base_out, 0);

    // Randomized traffic under mixed backpressure.
    base_out = out_cnt;
    bp_run   = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          send(($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), $urandom());
        end
        bp_run = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (bp_run) begin
          case ((cyc / 64) % 3)
            0:       out_ready = ($urandom_range(0, 1) == 1);
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b1;
          endcase
          cyc++;
          step();
        end
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_encoder.md
STREAM_ENCODER -- requirements
Module: stream_encoder

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 32, bus width; legal values are multiples of 32 and at least 32.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. Logic is rising-edge only.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the source presents a beat.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-007 SHALL have port in_mode, input, 2 bits: 00 small, 01 medium, 10 large, 11 reserved.
REQ-008 SHALL have port data_in, input, AMBA_WORD bits: payload, right-aligned (LSB-aligned).
REQ-009 SHALL have port out_valid, output, 1 bit: a codeword is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the sink accepts the codeword.
REQ-011 SHALL have port enc_out, output, AMBA_WORD bits: codeword, right-aligned, with upper bits zero.
REQ-012 SHALL have port out_mode, output, 2 bits: the mode of the presented codeword.
REQ-013 SHALL have port mode_err, output, 1 bit: a one-cycle pulse when a reserved-mode beat is dropped.

Function
REQ-014 SHALL define a transfer on each side as valid and ready both high at a rising clk edge.
REQ-015 SHALL build the codeword as {data, parity}:
- small: 4 data bits (data_in[3:0]) + 4 parity bits = 8-bit codeword.
- medium: 11 data bits + 5 parity bits = 16-bit codeword.
- large: 26 data bits + 6 parity bits = 32-bit codeword.
REQ-016 SHALL compute each parity bit as the XOR of the data bits selected by its package mask.
REQ-017 SHALL use these small-mode parity bits p[3:0], with d = data_in[3:0]:
- p3 = d2^d1^d0
- p2 = d3^d2^d1
- p1 = d3^d2^d0
- p0 = d3^d1^d0
REQ-018 SHALL ignore data_in bits above the data field of the selected mode.
REQ-019 SHALL drive enc_out bits above the codeword width to zero.
REQ-020 SHALL use a two-stage pipeline:
- stage 1 registers the data, mode and parity;
- stage 2 is the output register.
REQ-021 SHALL present the codeword on out_valid two cycles after input acceptance when out_ready is held high.
REQ-022 SHALL sustain one beat per cycle throughput with out_ready high.
REQ-023 SHALL let each stage advance when it is empty or when its downstream consumes it; in_ready = !s1_valid || s1_advance.
REQ-024 SHALL hold enc_out, out_mode and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL lose or duplicate no beat under any backpressure pattern, including out_ready toggling every cycle.
REQ-026 SHALL accept a reserved-mode beat normally but not forward it; mode_err pulses high in the cycle after acceptance.
REQ-027 SHALL let in_mode change on every beat; each beat is encoded in its own mode.
REQ-028 SHALL allow in_ready to depend combinationally on out_ready; there is no combinational path from in_valid to out_valid.

Reset
REQ-029 SHALL, while rst=1, clear on the next edge: both stage valids, out_valid, enc_out, out_mode, mode_err, and enc_count when present.
REQ-030 SHALL hold in_ready=0 while rst=1.
REQ-031 SHALL discard in-flight beats on reset asserted mid-stream; none are emitted afterwards.
REQ-032 SHALL raise in_ready in the first cycle after rst deasserts.

Configuration
REQ-033 SHALL use macro STREAM_ENCODER_STATS_EN to control the statistics counter.
REQ-034 SHALL, with STREAM_ENCODER_STATS_EN defined, add output enc_count [CNT_WIDTH-1:0]:
- it increments on each output transfer;
- it saturates at all-ones;
- it does not count dropped reserved beats.
REQ-035 SHALL, without STREAM_ENCODER_STATS_EN, have no enc_count port and no counter logic; all other behaviour is identical.

Structure
REQ-036 SHALL place in shared package enc_dec_pkg:
- the mode encodings;
- per-mode data and parity widths;
- per-mode parity mask constants.
The future decoder shares this package.
REQ-037 SHALL put the parity computation in combinational sub-module enc_parity_gen (inputs: data, mode; output: parity word). The parity computation is not duplicated inline.

Verification
REQ-038 SHALL cover: small, data_in=0x1, out_ready=1 -> enc_out=0x0000001B, out_mode=00, two cycles after acceptance.
REQ-039 SHALL cover: small, data_in=0xFFFFFFFF -> enc_out=0x000000FF; upper data bits are ignored.
REQ-040 SHALL cover: large, data_in=0, then medium, data_in=0, back-to-back -> enc_out=0 for both, out_mode 10 then 01, one beat per cycle.
REQ-041 SHALL cover: 8 beats with out_ready low for 3 cycles mid-stream -> output stalls, enc_out is held stable, and all 8 codewords are emitted in order.
REQ-042 SHALL cover: in_mode=11 beat between two small beats -> mode_err pulses once, and only the 2 small codewords are emitted.
REQ-043 SHALL cover: rst asserted with 2 beats in flight -> out_valid=0 next cycle, no stale output, enc_count=0 (STATS_EN build).
